// File: rtl/counter_pkg.sv
// Shared definitions for the count decoder: code type encodings, direction
// constants, FSM state type and gray/binary conversion helpers.
package counter_pkg;

  localparam int CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    CT_BIN     = 2'd0,
    CT_GRAY    = 2'd1,
    CT_RING    = 2'd2,
    CT_JOHNSON = 2'd3
  } count_type_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } dec_state_e;

  // Narrower codes are zero-extended; the leading zeros leave the result unchanged.
  function automatic logic [CNT_MAX_W-1:0] gray2bin(input logic [CNT_MAX_W-1:0] g);
    logic [CNT_MAX_W-1:0] b;
    b[CNT_MAX_W-1] = g[CNT_MAX_W-1];
    for (int i = CNT_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_MAX_W-1:0] bin2gray(input logic [CNT_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/count_code2bin.sv
// Combinational code-to-index decoder for binary, gray, ring and johnson
// counter codes, with an illegal-code flag.
module count_code2bin
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
) (
  input  logic [COUNT_WIDTH-1:0] code,
  input  logic [1:0]             code_type,
  output logic [COUNT_WIDTH-1:0] index,
  output logic                   illegal
);

  localparam int W = COUNT_WIDTH;

  int unsigned    ones;
  logic [W-1:0]   all_ones;
  logic [W-1:0]   msb_run;
  logic [W-1:0]   lsb_run;
  logic [W-1:0]   ring_idx;

  always_comb begin
    ones     = 0;
    ring_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (code[i]) begin
        ones     = ones + 1;
        ring_idx = W'(W - 1 - i);
      end
    end
    // The only legal johnson shapes with this many ones.
    all_ones = '1;
    msb_run  = ~(all_ones >> ones);
    lsb_run  = ~(all_ones << ones);

    index   = code;
    illegal = 1'b0;
    case (code_type)
      CT_BIN: begin
        index = code;
      end
      CT_GRAY: begin
        index = W'(gray2bin(CNT_MAX_W'(code)));
      end
      CT_RING: begin
        index   = ring_idx;
        illegal = (ones != 1);
      end
      default: begin
        illegal = !((code == msb_run) || (code == lsb_run));
        if (code[W-1] || (code == '0)) index = W'(ones);
        else                           index = W'(2 * W - ones);
      end
    endcase
  end

endmodule

// File: rtl/count_decoder.sv
// Sampled counter-code decoder with sequence tracking and lock detection.
// Error counter is built only when COUNT_DECODER_ERR_CNT_EN is defined.
//
// state | meaning
// IDLE  | no reference sample; next legal code becomes the reference
// ACQ   | reference held, counting consecutive legal advances
// LOCK  | LOCK_THRESH advances seen; holds and advances keep lock
module count_decoder
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   sample_valid_,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic [1:0]             count_type,
  input  logic                   count_dir,
  input  logic                   clear_,
  output logic [COUNT_WIDTH-1:0] bin_out,
  output logic                   bin_valid,
  output logic                   locked,
  output logic                   seq_err,
  output logic [7:0]             err_cnt
);

  localparam int W  = COUNT_WIDTH;
  localparam int SW = (LOCK_THRESH < 2) ? 1 : $clog2(LOCK_THRESH + 1);

  dec_state_e     state_q, state_d, eff_state;
  logic [SW-1:0]  streak_q, streak_d;
  logic [W-1:0]   prev_idx_q, prev_idx_d;
  logic [1:0]     prev_type_q, prev_type_d;
  logic [W-1:0]   bin_out_q, bin_out_d;
  logic           bin_valid_q, bin_valid_d;
  logic           seq_err_q, seq_err_d;

  logic [W-1:0]   dec_idx;
  logic           dec_illegal;
  logic [W:0]     period;
  logic [W:0]     idx_up;
  logic [W:0]     idx_dn;
  logic           is_hold;
  logic           is_adv;

  count_code2bin #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_code2bin (
    .code      (count_in),
    .code_type (count_type),
    .index     (dec_idx),
    .illegal   (dec_illegal)
  );

  // Successor arithmetic is one bit wider so the binary period 2^W fits.
  always_comb begin
    case (count_type)
      CT_BIN, CT_GRAY: period = {1'b1, {W{1'b0}}};
      CT_RING:         period = (W+1)'(W);
      default:         period = (W+1)'(2 * W);
    endcase
    idx_up = {1'b0, prev_idx_q} + 1'b1;
    if (idx_up == period) idx_up = '0;
    idx_dn = (prev_idx_q == '0) ? (period - 1'b1) : ({1'b0, prev_idx_q} - 1'b1);
    is_hold = (dec_idx == prev_idx_q);
    is_adv  = (count_dir == DIR_UP) ? ({1'b0, dec_idx} == idx_up)
                                    : ({1'b0, dec_idx} == idx_dn);
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    prev_idx_d  = prev_idx_q;
    prev_type_d = prev_type_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    eff_state   = state_q;

    if (!clear_) begin
      state_d  = ST_IDLE;
      streak_d = '0;
    end else if (!sample_valid_) begin
      bin_valid_d = 1'b1;
      bin_out_d   = dec_idx;
      prev_type_d = count_type;
      // A change of code type restarts tracking as if from IDLE.
      eff_state   = (count_type != prev_type_q) ? ST_IDLE : state_q;

      if (eff_state == ST_IDLE) begin
        if (dec_illegal) begin
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d    = ST_ACQ;
          streak_d   = '0;
          prev_idx_d = dec_idx;
        end
      end else if (dec_illegal) begin
        // No usable index: keep the old reference.
        seq_err_d = 1'b1;
        state_d   = ST_ACQ;
        streak_d  = '0;
      end else if (is_hold) begin
        state_d = state_q;
      end else if (is_adv) begin
        prev_idx_d = dec_idx;
        if (state_q == ST_ACQ) begin
          if (streak_q == SW'(LOCK_THRESH - 1)) begin
            state_d  = ST_LOCK;
            streak_d = SW'(LOCK_THRESH);
          end else begin
            streak_d = streak_q + 1'b1;
          end
        end
      end else begin
        // Legal code, wrong successor: re-anchor on the new index.
        seq_err_d  = 1'b1;
        state_d    = ST_ACQ;
        streak_d   = '0;
        prev_idx_d = dec_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      prev_idx_q  <= '0;
      prev_type_q <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      prev_idx_q  <= prev_idx_d;
      prev_type_q <= prev_type_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

`ifdef COUNT_DECODER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!clear_)                              err_cnt_d = '0;
    else if (seq_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_count_decoder.sv
// Directed and randomized bench for count_decoder (COUNT_WIDTH=4, LOCK_THRESH=3)
// against a table-lookup reference model of the code sequences.
module tb_count_decoder;

  localparam int W      = 4;
  localparam int THRESH = 3;
`ifdef COUNT_DECODER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         reset_;
  logic         sample_valid_;
  logic [W-1:0] count_in;
  logic [1:0]   count_type;
  logic         count_dir;
  logic         clear_;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         locked;
  logic         seq_err;
  logic [7:0]   err_cnt;

  count_decoder #(
    .COUNT_WIDTH (W),
    .LOCK_THRESH (THRESH)
  ) dut (
    .clk           (clk),
    .reset_        (reset_),
    .sample_valid_ (sample_valid_),
    .count_in      (count_in),
    .count_type    (count_type),
    .count_dir     (count_dir),
    .clear_        (clear_),
    .bin_out       (bin_out),
    .bin_valid     (bin_valid),
    .locked        (locked),
    .seq_err       (seq_err),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: 0 untracked, 1 acquiring, 2 locked.
  int m_mode, m_streak, m_prev, m_prev_t, m_errs, m_bin;
  bit m_bin_known, m_valid, m_err;

  function automatic int period(input int t);
    if (t < 2)  return 1 << W;
    if (t == 2) return W;
    return 2 * W;
  endfunction

  function automatic int enc(input int t, input int i);
    case (t)
      0:       return i;
      1:       return i ^ (i >> 1);
      2:       return 1 << (W - 1 - i);
      default: return (i <= W) ? (((1 << i) - 1) << (W - i)) : ((1 << (2 * W - i)) - 1);
    endcase
  endfunction

  function automatic int dec(input int t, input int code);
    for (int i = 0; i < period(t); i++) begin
      if (enc(t, i) == code) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_prev = 0; m_prev_t = 0; m_errs = 0;
    m_bin = 0; m_bin_known = 1'b1; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_flag_err();
    m_err = 1'b1;
    if (m_errs < 255) m_errs++;
  endtask

  task automatic model_step(input bit sv_n, input int code, input int t, input bit dir, input bit clr_n);
    int idx, p, mode_eff;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!clr_n) begin
      m_mode = 0; m_streak = 0; m_errs = 0;
      return;
    end
    if (sv_n) return;
    m_valid  = 1'b1;
    idx      = dec(t, code);
    p        = period(t);
    if (idx >= 0) begin m_bin = idx; m_bin_known = 1'b1; end
    else          m_bin_known = 1'b0;
    mode_eff = (t != m_prev_t) ? 0 : m_mode;
    m_prev_t = t;
    if (mode_eff == 0) begin
      if (idx < 0) begin model_flag_err(); m_mode = 0; end
      else begin m_mode = 1; m_streak = 0; m_prev = idx; end
    end else if (idx < 0) begin
      model_flag_err(); m_mode = 1; m_streak = 0;
    end else if (idx == m_prev) begin
      // hold
    end else if (idx == (m_prev + (dir ? 1 : p - 1)) % p) begin
      m_prev = idx;
      if (m_mode == 1) begin
        m_streak++;
        if (m_streak >= THRESH) m_mode = 2;
      end
    end else begin
      model_flag_err(); m_mode = 1; m_streak = 0; m_prev = idx;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("bin_valid", 32'(bin_valid), 32'(m_valid));
    chk("seq_err",   32'(seq_err),   32'(m_err));
    chk("locked",    32'(locked),    32'(m_mode == 2));
    chk("err_cnt",   32'(err_cnt),   ERR_EN ? m_errs : 0);
    if (m_bin_known) chk("bin_out", 32'(bin_out), m_bin);
  endtask

  task automatic do_cycle(input bit sv_n, input int code, input int t, input bit dir, input bit clr_n);
    sample_valid_ = sv_n;
    count_in      = W'(code);
    count_type    = 2'(t);
    count_dir     = dir;
    clear_        = clr_n;
    @(posedge clk);
    #1;
    model_step(sv_n, code, t, dir, clr_n);
    check_all();
    sample_valid_ = 1'b1;
    clear_        = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bin_out"},   32'(bin_out),   0);
    chk({tag, "_bin_valid"}, 32'(bin_valid), 0);
    chk({tag, "_locked"},    32'(locked),    0);
    chk({tag, "_seq_err"},   32'(seq_err),   0);
    chk({tag, "_err_cnt"},   32'(err_cnt),   0);
  endtask

  int c31[5] = '{0, 1, 2, 3, 4};
  int c32[5] = '{4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
  int e32[5] = '{3, 2, 1, 0, 15};
  int c33[5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  int e33[5] = '{0, 1, 2, 3, 0};
  int c34[4] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};

  initial begin
    int r_t, code, p, base, sel;
    bit r_dir, sv_n, clr_n;

    reset_ = 1'b0; sample_valid_ = 1'b1; clear_ = 1'b1;
    count_in = '0; count_type = '0; count_dir = 1'b1;
    model_reset();
    #1;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    reset_ = 1'b1;

    // Binary up: lock on the fourth sample (value 3).
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, c31[i], 0, 1'b1, 1'b1);
      chk("bin_up_idx", 32'(bin_out), c31[i]);
      if (i == 2) chk("bin_up_not_yet_locked", 32'(locked), 0);
      if (i == 3) chk("bin_up_locked", 32'(locked), 1);
    end

    // Gray down with wrap 0 -> 15.
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, c32[i], 1, 1'b0, 1'b1);
      chk("gray_dn_idx", 32'(bin_out), e32[i]);
    end
    chk("gray_dn_locked", 32'(locked), 1);
    chk("gray_dn_no_err", 32'(seq_err), 0);

    // Ring up with wrap, then an illegal two-hot code.
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, c33[i], 2, 1'b1, 1'b1);
      chk("ring_up_idx", 32'(bin_out), e33[i]);
    end
    chk("ring_up_locked", 32'(locked), 1);
    do_cycle(1'b0, 4'b0110, 2, 1'b1, 1'b1);
    chk("ring_illegal_err", 32'(seq_err), 1);
    chk("ring_illegal_unlock", 32'(locked), 0);
    chk("ring_illegal_cnt", 32'(err_cnt), ERR_EN ? 1 : 0);

    // Johnson up, then a skip to index 6.
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, c34[i], 3, 1'b1, 1'b1);
      chk("john_up_idx", 32'(bin_out), i);
    end
    chk("john_up_locked", 32'(locked), 1);
    do_cycle(1'b0, 4'b0011, 3, 1'b1, 1'b1);
    chk("john_skip_err", 32'(seq_err), 1);
    chk("john_skip_cnt", 32'(err_cnt), ERR_EN ? 2 : 0);

    // Re-lock from index 6, then assert reset between edges.
    do_cycle(1'b0, 4'b0001, 3, 1'b1, 1'b1);
    do_cycle(1'b0, 4'b0000, 3, 1'b1, 1'b1);
    do_cycle(1'b0, 4'b1000, 3, 1'b1, 1'b1);
    chk("pre_reset_locked", 32'(locked), 1);
    chk("pre_reset_cnt", 32'(err_cnt), ERR_EN ? 2 : 0);
    #2;
    reset_ = 1'b0;
    #1;
    check_zero("reset_mid");
    reset_ = 1'b1;
    model_reset();

    // Clear colliding with a sample.
    for (int i = 0; i < 4; i++) do_cycle(1'b0, i, 0, 1'b1, 1'b1);
    do_cycle(1'b0, 7, 0, 1'b1, 1'b1);
    chk("pre_clear_err", 32'(seq_err), 1);
    do_cycle(1'b0, 9, 0, 1'b1, 1'b0);
    chk("clear_no_valid", 32'(bin_valid), 0);
    chk("clear_cnt_zero", 32'(err_cnt), 0);
    chk("clear_bin_held", 32'(bin_out), 7);
    do_cycle(1'b0, 12, 0, 1'b1, 1'b1);
    chk("after_clear_first_no_err", 32'(seq_err), 0);
    chk("after_clear_valid", 32'(bin_valid), 1);

    // Error counter saturation with all-zero ring codes.
    for (int i = 0; i < 260; i++) do_cycle(1'b0, 0, 2, 1'b1, 1'b1);
    chk("err_cnt_saturated", 32'(err_cnt), ERR_EN ? 255 : 0);
    do_cycle(1'b1, 0, 2, 1'b1, 1'b0);

    // Randomized traffic.
    r_t = 0; r_dir = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 4) r_t = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) r_dir = !r_dir;
      sv_n  = ($urandom_range(0, 9) < 3);
      clr_n = !($urandom_range(0, 99) < 2);
      p     = period(r_t);
      base  = m_prev % p;
      sel   = int'($urandom_range(0, 9));
      if (sel <= 5)      code = enc(r_t, (base + (r_dir ? 1 : p - 1)) % p);
      else if (sel <= 7) code = enc(r_t, base);
      else if (sel == 8) code = enc(r_t, int'($urandom_range(0, p - 1)));
      else               code = int'($urandom_range(0, (1 << W) - 1));
      do_cycle(sv_n, code, r_t, r_dir, clr_n);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/count_decoder.md
COUNT_DECODER -- requirements
Module: count_decoder

Interface
REQ-001 Parameter COUNT_WIDTH, default 4, width of the sampled count code; SHALL be legal for values >= 3.
REQ-002 Parameter LOCK_THRESH, default 3, consecutive legal advances required to declare lock.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_  in  1  reset, asynchronous and active-low.
REQ-005 sample_valid_  in  1  active-low; count_in, count_type and count_dir are sampled this cycle.
REQ-006 count_in  in  COUNT_WIDTH  counter code to decode.
REQ-007 count_type  in  2  code type: 0 binary, 1 gray, 2 ring, 3 johnson.
REQ-008 count_dir  in  1  expected direction: 1 up, 0 down.
REQ-009 clear_  in  1  active-low synchronous clear of tracking state and error count.
REQ-010 bin_out  out  COUNT_WIDTH  decoded index of the last sample.
REQ-011 bin_valid  out  1  one-cycle pulse: bin_out updated.
REQ-012 locked  out  1  level: sequence tracked and legal.
REQ-013 seq_err  out  1  one-cycle pulse, coincident with bin_valid: illegal code or illegal successor.
REQ-014 err_cnt  out  8  saturating count of seq_err pulses.

Function
REQ-015 Decode: binary identity; gray via gray-to-binary; ring index = COUNT_WIDTH-1-p for single set bit p; johnson index = ones-count if MSB=1 or code=0, else 2*COUNT_WIDTH-ones-count.
REQ-016 Illegal code: ring not one-hot (incl. all-zero); johnson not a contiguous run of ones anchored at MSB or LSB; binary/gray never illegal.
REQ-017 Period: 2^COUNT_WIDTH binary/gray, COUNT_WIDTH ring, 2*COUNT_WIDTH johnson; successor arithmetic SHALL wrap modulo period.
REQ-018 Legal successor: index equal to previous (hold) or previous +1 (dir=1) / -1 (dir=0) modulo period.
REQ-019 Latency: bin_out, bin_valid, seq_err, locked SHALL update on the clock edge that samples sample_valid_=0; one cycle.
REQ-020 FSM states IDLE, ACQ, LOCK; streak counter tracks consecutive legal advances.
REQ-021 IDLE: any legal-code sample -> ACQ, streak=0, no seq_err; illegal code -> seq_err, stay IDLE.
REQ-022 ACQ: advance -> streak+1, at LOCK_THRESH -> LOCK with locked=1 same edge; hold -> no change; illegal -> seq_err, streak=0, stay ACQ.
REQ-023 LOCK: advance or hold -> stay; illegal -> seq_err, locked=0, ACQ, streak=0.
REQ-024 count_type differing from previous sample's type -> treated as IDLE first sample, no seq_err.
REQ-025 clear_=0 -> IDLE, locked=0, streak=0, err_cnt=0, bin_out held; clear_ wins over simultaneous sample (sample discarded, no bin_valid).
REQ-026 err_cnt saturates at 255.

Reset
REQ-027 reset_=0 SHALL immediately force bin_out=0, bin_valid=0, locked=0, seq_err=0, err_cnt=0, FSM=IDLE, streak=0, independent of clk, including mid-sequence.

Configuration
REQ-028 Macro COUNT_DECODER_ERR_CNT_EN defined: err_cnt per REQ-026; undefined: counter not built, err_cnt tied 0, seq_err unaffected.

Structure
REQ-029 Package counter_pkg SHALL hold count_type encodings, direction constants, and shared gray/binary conversion functions.
REQ-030 Combinational sub-module count_code2bin SHALL implement REQ-015/016 (index + illegal flag).

Verification (COUNT_WIDTH=4, LOCK_THRESH=3)
REQ-031 Binary up samples 0,1,2,3,4 -> bin_out 0..4, locked=1 with sample 3, no seq_err.
REQ-032 Gray down 0010,0011,0001,0000,1000 -> bin_out 3,2,1,0,15, wrap legal, locked=1.
REQ-033 Ring up 1000,0100,0010,0001,1000 then 0110 -> indices 0,1,2,3,0; 0110 gives seq_err, locked=0, err_cnt=1.
REQ-034 Johnson up 0000,1000,1100,1110 then 0011 -> indices 0,1,2,3 locked; 0011 (index 6) gives seq_err, err_cnt+1.
REQ-035 Locked with err_cnt=2, reset_ low between edges -> all outputs 0 before next clk.
REQ-036 clear_=0 and sample_valid_=0 same cycle -> no bin_valid, err_cnt=0, FSM IDLE.
